// File: rtl/disp_pkg.sv
// Shared definitions for the scrolling 7-segment display controller:
// FSM encodings, the blank character code and the character-to-segment table.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_READY  = 2'd2,
        ST_SCROLL = 2'd3
    } state_e;

    localparam logic [3:0] CH_BLANK = 4'hF;

    // Segment patterns {g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0000000,  // F (blank)
        7'b1111001,  // E
        7'b1011110,  // D
        7'b0111001,  // C
        7'b1111100,  // B
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit character code to active-high 7-segment pattern.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[code];

endmodule

// File: rtl/disp_scroll_ctrl.sv
// Buffered message load, scroll FSM and digit refresh multiplexing for a
// time-multiplexed 7-segment display.
module disp_scroll_ctrl
    import disp_pkg::*;
#(
    parameter int MSG_LEN = 8,
    parameter int DIGITS  = 4,
    parameter int REFRESH = 50_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              clear,
    input  logic              wr_valid,
    input  logic [3:0]        wr_data,
    output logic              wr_ready,
    input  logic              start,
    input  logic              repeat_en,
    output logic              busy,
    output logic              done,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_sel
);

    localparam int PW = $clog2(MSG_LEN + 1);
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

    localparam logic [PW-1:0] LEN_P    = PW'(MSG_LEN);
    localparam logic [PW-1:0] LAST_PTR = PW'(MSG_LEN - 1);
    localparam logic [PW:0]   LEN_W    = (PW + 1)'(MSG_LEN);
    localparam logic [DW-1:0] LAST_DIG = DW'(DIGITS - 1);
    localparam logic [RW-1:0] LAST_CNT = RW'(REFRESH - 1);

    state_e             state_q, state_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [DW-1:0]      dig_idx_q, dig_idx_d;
    logic [RW-1:0]      refresh_cnt_q, refresh_cnt_d;
    logic [6:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  dig_sel_q, dig_sel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [3:0]         msg_buf [MSG_LEN];
    logic [3:0]         win_char [DIGITS];
    logic [3:0]         sel_char;
    logic               wr_accept;

    assign wr_ready  = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && (wr_ptr_q < LEN_P);
    assign wr_accept = wr_valid && wr_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        pos_d    = pos_q;
        done_d   = 1'b0;
        if (clear) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            pos_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (wr_accept) begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        state_d  = (wr_ptr_q == LAST_PTR) ? ST_READY : ST_LOAD;
                    end
                end
                ST_READY: begin
                    if (start) begin
                        state_d = ST_SCROLL;
                        pos_d   = '0;
                    end
                end
                ST_SCROLL: begin
                    // pos runs one past the last character so the message fully scrolls off.
                    if (tick) begin
                        if (pos_q < LEN_P) begin
                            pos_d = pos_q + PW'(1);
                        end else begin
                            pos_d = '0;
                            if (!repeat_en) begin
                                state_d = ST_READY;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_SCROLL);
    end

    always_comb begin
        refresh_cnt_d = refresh_cnt_q + RW'(1);
        dig_idx_d     = dig_idx_q;
        if (refresh_cnt_q == LAST_CNT) begin
            refresh_cnt_d = '0;
            dig_idx_d     = (dig_idx_q == LAST_DIG) ? '0 : dig_idx_q + DW'(1);
        end
        dig_sel_d = DIGITS'(1) << dig_idx_d;
    end

    // Window characters are built from next-cycle pos so seg and dig_sel update together.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_win
            logic [PW:0] idx;
            assign idx          = {1'b0, pos_d} + (PW + 1)'(gi);
            assign win_char[gi] = (idx < LEN_W) ? msg_buf[idx[AW-1:0]] : CH_BLANK;
        end
    endgenerate

    assign sel_char = (state_d == ST_SCROLL) ? win_char[dig_idx_d] : CH_BLANK;

    seg7_decode u_dec (
        .code (sel_char),
        .seg  (seg_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            pos_q         <= '0;
            dig_idx_q     <= '0;
            refresh_cnt_q <= '0;
            seg_q         <= '0;
            dig_sel_q     <= DIGITS'(1);
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            pos_q         <= pos_d;
            dig_idx_q     <= dig_idx_d;
            refresh_cnt_q <= refresh_cnt_d;
            seg_q         <= seg_d;
            dig_sel_q     <= dig_sel_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept && !clear) begin
            msg_buf[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
